// File: rtl/common_enums.sv
`default_nettype none
//------------------------------------------------------------------------------
// common_enums : shared VGA 640x480@60 timing defaults and screen-state type
// Rev 1.0
//------------------------------------------------------------------------------
package common_enums;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;

  localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef enum logic [1:0] {
    SCREEN_ACTIVE = 2'd0,
    SCREEN_VBLANK = 2'd1,
    SCREEN_UPDATE = 2'd2,
    SCREEN_IDLE   = 2'd3
  } screen_state_t;

endpackage
`default_nettype wire

// File: rtl/sig_delay.sv
`default_nettype none
//------------------------------------------------------------------------------
// sig_delay : DEPTH-stage registered delay line with a reset value per stage
// Rev 1.0
//------------------------------------------------------------------------------
module sig_delay #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// vga_timing_gen : VGA raster counters, delayed sync/blank, vblank update grant
// Rev 1.0
//------------------------------------------------------------------------------
module vga_timing_gen
  import common_enums::*;
#(
  parameter int H_VISIBLE  = VGA_H_VISIBLE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_VISIBLE  = VGA_V_VISIBLE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int PIPE_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       active,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       frame_start,
  output logic       vblank_start,
  output logic [7:0] frame_count,
  input  logic       upd_req,
  output logic       upd_ack
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       upd_ack_q, upd_ack_d;
  logic       granted_q, granted_d;
  logic       h_wrap, frame_wrap, in_window;
  logic       hs_n_dec, vs_n_dec, active_dec;
  logic [2:0] pix_dly;

  always_comb begin
    h_wrap        = (hcount_q == H_LAST);
    frame_wrap    = h_wrap && (vcount_q == V_LAST);
    hcount_d      = h_wrap ? 10'd0 : hcount_q + 10'd1;
    vcount_d      = vcount_q;
    if (h_wrap) vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
    frame_count_d = frame_wrap ? frame_count_q + 8'd1 : frame_count_q;

    // The last cycle of the frame is excluded so the registered ack can never land on vcount 0.
    in_window = (vcount_q >= V_VIS) && !frame_wrap;
    upd_ack_d = 1'b0;
    granted_d = granted_q;
    if (frame_start) granted_d = 1'b0;
    if (upd_req && in_window && !granted_q) begin
      upd_ack_d = 1'b1;
      granted_d = 1'b1;
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hcount_q      <= 10'd0;
      vcount_q      <= 10'd0;
      frame_count_q <= 8'd0;
      upd_ack_q     <= 1'b0;
      granted_q     <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      frame_count_q <= frame_count_d;
      upd_ack_q     <= upd_ack_d;
      granted_q     <= granted_d;
    end
  end

  assign active_dec = (hcount_q < H_VIS) && (vcount_q < V_VIS);
  assign hs_n_dec   = !((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST));
  assign vs_n_dec   = !((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST));

  sig_delay #(
    .WIDTH    (3),
    .DEPTH    (PIPE_DELAY),
    .RESET_VAL(3'b110)
  ) u_pix_delay (
    .clk_i(vga_clk),
    .rst_i(reset),
    .d_i  ({hs_n_dec, vs_n_dec, active_dec}),
    .q_o  (pix_dly)
  );

  assign hcount       = hcount_q;
  assign vcount       = vcount_q;
  assign active       = active_dec;
  assign frame_start  = (hcount_q == 10'd0) && (vcount_q == 10'd0);
  assign vblank_start = (hcount_q == 10'd0) && (vcount_q == V_VIS);
  assign frame_count  = frame_count_q;
  assign upd_ack      = upd_ack_q;
  assign vga_hs       = pix_dly[2];
  assign vga_vs       = pix_dly[1];
  assign vga_blank_n  = pix_dly[0];
  assign vga_sync_n   = 1'b0;

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIPE_DELAY, 1, clocks from counter value to matching pixel data; legal range 1..4

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- vga_clk  in  1  single 25 MHz pixel clock
- reset  in  1  asynchronous, active-high reset
- hcount  out  10  horizontal pixel counter (address phase)
- vcount  out  10  vertical line counter (address phase)
- active  out  1  hcount<H_VISIBLE and vcount<V_VISIBLE, address phase
- vga_hs  out  1  horizontal sync, active-low, pixel phase
- vga_vs  out  1  vertical sync, active-low, pixel phase
- vga_blank_n  out  1  high during visible pixels, pixel phase
- vga_sync_n  out  1  composite sync, held 0
- frame_start  out  1  one-cycle pulse at hcount=0, vcount=0
- vblank_start  out  1  one-cycle pulse at hcount=0, vcount=V_VISIBLE
- frame_count  out  8  frames completed, wraps 255->0
- upd_req  in  1  board/highlight update request, level, held until ack
- upd_ack  out  1  one-cycle grant; updates are safe while vcount>=V_VISIBLE

Function
REQ-003 H_TOTAL=H_VISIBLE+H_FP+H_SYNC+H_BP (800) and V_TOTAL=V_VISIBLE+V_FP+V_SYNC+V_BP (525) SHALL be used.
REQ-004 hcount SHALL increment every cycle and wrap H_TOTAL-1 -> 0.
REQ-005 vcount SHALL increment only on the cycle hcount wraps, and wrap V_TOTAL-1 -> 0 on the same cycle hcount wraps from H_TOTAL-1.
REQ-006 frame_count SHALL increment on the cycle both counters wrap.
REQ-007 active, frame_start and vblank_start SHALL be combinational decodes of the current counters (0 cycles latency).
REQ-008 Sync decode: hsync is low for hcount in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] = [656,751]; vsync is low for vcount in [490,491].
REQ-009 vga_hs, vga_vs and vga_blank_n SHALL equal the decode of the counters PIPE_DELAY cycles earlier, through a registered delay line.
REQ-010 Grant window SHALL be vcount in [V_VISIBLE, V_TOTAL-1]; at most one upd_ack pulse per window.
REQ-011 upd_ack SHALL be registered: when upd_req=1 inside the window and no grant has yet been issued in that window, upd_ack=1 on the next cycle.
REQ-012 A request first seen on the window's opening cycle SHALL be acked on the following cycle.
REQ-013 A request pending at window close SHALL wait for the next window; a grant SHALL never be issued with vcount<V_VISIBLE.
REQ-014 The per-window grant-issued flag SHALL clear at frame_start.

Reset
REQ-015 During reset, the outputs SHALL take these values: hcount=0, vcount=0, frame_count=0, upd_ack=0, grant flag=0.
REQ-016 During reset, every delay-line stage SHALL hold the inactive values: vga_hs=1, vga_vs=1, vga_blank_n=0.
REQ-017 Reset asserted mid-frame SHALL restart timing at 0,0 on the first clock after deassertion, and SHALL drop any pending grant.

Structure
REQ-018 The VGA timing defaults and H_TOTAL/V_TOTAL SHALL live in the shared package common_enums, alongside screen_state_t.
REQ-019 The delay line SHALL be one sub-module, sig_delay, parameterised by width and depth, with its own reset.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset released -> hcount 0..799 then vcount=1; after 420000 clocks, frame_start and frame_count=1.
- hcount=655 -> 656 at vcount=10 -> vga_hs falls 1 cycle later (PIPE_DELAY=1), low for exactly 96 cycles.
- vcount 489->490 -> vga_vs low for 2x800 cycles; vga_blank_n=0 throughout vcount>=480.
- upd_req raised at vcount=100 -> no upd_ack until vcount=480, hcount=1 (single pulse); req held -> no second ack in that frame; next ack occurs in the following vblank.
- upd_req raised at vcount=524, hcount=799 -> no ack, frame wraps, ack in the next window.
- reset pulsed at vcount=300, hcount=400 -> all outputs at reset values immediately (async); counters restart at 0,0; PIPE_DELAY=3 run -> syncs lag the decode by exactly 3 cycles.
